id_ex_fwd_pipe: RTL and testbench
=================================

// Module: id_ex_fwd_pipe
// PURPOSE
//  Parametrised decode-to-execute pipeline stage. Resolves rs1/rs2 operands against NUM_FWD prioritised
//  forwarding sources, detects use-before-ready hazards (pending producers such as loads), and holds
//  the ID/EX register with valid/ready handshake, flush and bubble insertion. Sits between the regfile
//  read/decode logic and the EX stage. Resolved operands also feed branch comparison and jalr targets.
// PARAMETERS
//  XLEN       32  datapath width
//  RA_W       5   register address width
//  NUM_FWD    3   forwarding sources; index 0 = highest priority (youngest producer)
//  CTRL_W     10  packed control bundle width (RegWrite, ALUsrc, WriteSrc, ALUOp, MemRead, MemWrite, ...)
//  CNT_W      8   width of hazard-stall counter
//  MAX_STALL  16  consecutive hazard cycles before stall_timeout_o sets
// PORTS
//  clk_i          in   1               clock
//  rst_i          in   1               synchronous reset, active-high
//  in_valid_i     in   1               decoded instruction present
//  in_ready_o     out  1               stage accepts instruction this cycle
//  rs1_i, rs2_i   in   RA_W            source register addresses
//  rd_i           in   RA_W            destination register address
//  ctrl_i         in   CTRL_W          decoded control bundle
//  rf_op1_i       in   XLEN            regfile RD1
//  rf_op2_i       in   XLEN            regfile RD2
//  imm_i          in   XLEN            sign-extended immediate
//  pc_plus4_i     in   XLEN            PC+4 of instruction
//  fwd_valid_i    in   NUM_FWD         source k will write fwd_rd
//  fwd_pending_i  in   NUM_FWD         source k value not yet available (e.g. load in EX)
//  fwd_rd_i       in   NUM_FWD*RA_W    source k destination, k at [k*RA_W +: RA_W]
//  fwd_data_i     in   NUM_FWD*XLEN    source k data, k at [k*XLEN +: XLEN]
//  flush_i        in   1               kill instruction entering the register this cycle
//  out_ready_i    in   1               EX accepts register contents
//  fwd_op1_o      out  XLEN            combinational resolved rs1 operand
//  fwd_op2_o      out  XLEN            combinational resolved rs2 operand
//  hazard_o       out  1               combinational use-before-ready hazard
//  out_valid_o, ctrl_o, op1_o, op2_o, imm_o, pc_plus4_o, rs1_o, rs2_o, rd_o  out  registered ID/EX contents
//  stall_cnt_o    out  CNT_W           total hazard cycles, saturating
//  stall_timeout_o out 1               sticky: hazard held >= MAX_STALL consecutive cycles
// BEHAVIOUR
//  - Match k for rsN: fwd_valid_i[k] && fwd_rd_i[k]==rsN && rsN!=0. Lowest matching k wins.
//  - fwd_opN_o = winning fwd_data_i; no match -> rf_opN_i. Pure mux; no latches.
//  - hazard_o = in_valid_i && (winner for rs1 or rs2 has fwd_pending_i set).
//    A pending lower-priority source shadowed by a higher match is no hazard.
//  - load_en = out_ready_i || !out_valid_o. in_ready_o = load_en && (!hazard_o || flush_i).
//  - On clk with load_en, priority order:
//    flush_i -> out_valid_o=0, ctrl_o=0.
//    else in_valid_i && !hazard_o -> capture all fields with forwarded operands, out_valid_o=1.
//    else -> bubble: out_valid_o=0, ctrl_o=0. Data fields are don't-care.
//  - !load_en: all registered outputs hold. flush_i still clears out_valid_o/ctrl_o next cycle.
//  - Latency: 1 cycle input to output. Full throughput when out_ready_i=1 and no hazard.
//  - stall_cnt_o +1 each cycle hazard_o && !flush_i; saturates at 2^CNT_W-1, no wrap.
//  - Consecutive-hazard run counter clears on any non-hazard cycle.
//    Run reaching MAX_STALL sets stall_timeout_o, held until rst_i.
//  - rst_i (any cycle, incl. mid-stall): out_valid_o=0, ctrl_o=0.
//    op1/op2/imm/pc_plus4/rs1/rs2/rd outputs = 0. Counters=0, stall_timeout_o=0.
// TESTING
//  - rs1=5, fwd0 rd=5 data=0xAAAA, fwd1 rd=5 data=0xBBBB, none pending -> op1_o=0xAAAA one cycle later.
//  - rs2=0, fwd0 valid rd=0 data=0x1234, rf_op2_i=0 -> op2_o=0, no hazard.
//  - rs1=7, fwd0 rd=7 pending=1 for 2 cycles, then data 0x55 ready -> in_ready_o=0 for 2 cycles.
//    Two bubbles out (out_valid_o=0, ctrl_o=0), then op1_o=0x55, stall_cnt_o=2.
//  - out_ready_i=0 with out_valid_o=1 -> outputs hold, in_ready_o=0.
//    flush_i pulse -> out_valid_o=0 next cycle.
//  - Hazard held 16 cycles, CNT_W=4 -> stall_timeout_o=1 at cycle 16. stall_cnt_o saturates at 15.
//    rst_i -> all outputs 0.
//  - Back-to-back 8 instructions, out_ready_i=1, no hazards -> 8 consecutive out_valid_o=1 in order.

Source files
------------

// File: rtl/id_ex_fwd_pipe.sv
// Decode-to-execute pipeline stage: resolves rs1/rs2 against prioritised forwarding sources,
// detects use-before-ready hazards and holds the ID/EX register behind a valid/ready handshake.
module id_ex_fwd_pipe #(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int NUM_FWD   = 3,
  parameter int CTRL_W    = 10,
  parameter int CNT_W     = 8,
  parameter int MAX_STALL = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [RA_W-1:0]         rs1_i,
  input  logic [RA_W-1:0]         rs2_i,
  input  logic [RA_W-1:0]         rd_i,
  input  logic [CTRL_W-1:0]       ctrl_i,
  input  logic [XLEN-1:0]         rf_op1_i,
  input  logic [XLEN-1:0]         rf_op2_i,
  input  logic [XLEN-1:0]         imm_i,
  input  logic [XLEN-1:0]         pc_plus4_i,
  input  logic [NUM_FWD-1:0]      fwd_valid_i,
  input  logic [NUM_FWD-1:0]      fwd_pending_i,
  input  logic [NUM_FWD*RA_W-1:0] fwd_rd_i,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
  input  logic                    flush_i,
  input  logic                    out_ready_i,
  output logic [XLEN-1:0]         fwd_op1_o,
  output logic [XLEN-1:0]         fwd_op2_o,
  output logic                    hazard_o,
  output logic                    out_valid_o,
  output logic [CTRL_W-1:0]       ctrl_o,
  output logic [XLEN-1:0]         op1_o,
  output logic [XLEN-1:0]         op2_o,
  output logic [XLEN-1:0]         imm_o,
  output logic [XLEN-1:0]         pc_plus4_o,
  output logic [RA_W-1:0]         rs1_o,
  output logic [RA_W-1:0]         rs2_o,
  output logic [RA_W-1:0]         rd_o,
  output logic [CNT_W-1:0]        stall_cnt_o,
  output logic                    stall_timeout_o
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  // Returns {pending, data} of the lowest-index matching source; x0 never forwards.
  function automatic logic [XLEN:0] resolve(
    input logic [RA_W-1:0]         rs,
    input logic [XLEN-1:0]         rf,
    input logic [NUM_FWD-1:0]      vld,
    input logic [NUM_FWD-1:0]      pnd,
    input logic [NUM_FWD*RA_W-1:0] rds,
    input logic [NUM_FWD*XLEN-1:0] dat
  );
    logic [XLEN:0] res;
    logic          hit;
    res = {1'b0, rf};
    hit = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (!hit && vld[k] && (rds[k*RA_W +: RA_W] == rs) && (rs != '0)) begin
        hit = 1'b1;
        res = {pnd[k], dat[k*XLEN +: XLEN]};
      end
    end
    return res;
  endfunction

  logic [XLEN:0]      res1_s, res2_s;
  logic               load_en_s;
  logic               valid_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [XLEN-1:0]    op1_q, op2_q, imm_q, pc_q;
  logic [RA_W-1:0]    rs1_q, rs2_q, rd_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               to_q, to_d;

  always_comb begin
    res1_s     = resolve(rs1_i, rf_op1_i, fwd_valid_i, fwd_pending_i, fwd_rd_i, fwd_data_i);
    res2_s     = resolve(rs2_i, rf_op2_i, fwd_valid_i, fwd_pending_i, fwd_rd_i, fwd_data_i);
    fwd_op1_o  = res1_s[XLEN-1:0];
    fwd_op2_o  = res2_s[XLEN-1:0];
    hazard_o   = in_valid_i && (res1_s[XLEN] || res2_s[XLEN]);
    load_en_s  = out_ready_i || !valid_q;
    in_ready_o = load_en_s && (!hazard_o || flush_i);
  end

  // A flushed hazard cycle is not a stall: the instruction is being killed anyway.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    to_d  = to_q;
    if (hazard_o && !flush_i) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
      if (run_d == RUN_MAX) to_d = 1'b1;
    end else begin
      run_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      to_q  <= to_d;
      if (load_en_s && !flush_i && in_valid_i && !hazard_o) begin
        valid_q <= 1'b1;
        ctrl_q  <= ctrl_i;
        op1_q   <= fwd_op1_o;
        op2_q   <= fwd_op2_o;
        imm_q   <= imm_i;
        pc_q    <= pc_plus4_i;
        rs1_q   <= rs1_i;
        rs2_q   <= rs2_i;
        rd_q    <= rd_i;
      end else if (load_en_s || flush_i) begin
        // Flush or bubble; data fields keep their old (don't-care) values.
        valid_q <= 1'b0;
        ctrl_q  <= '0;
      end
    end
  end

  assign out_valid_o     = valid_q;
  assign ctrl_o          = ctrl_q;
  assign op1_o           = op1_q;
  assign op2_o           = op2_q;
  assign imm_o           = imm_q;
  assign pc_plus4_o      = pc_q;
  assign rs1_o           = rs1_q;
  assign rs2_o           = rs2_q;
  assign rd_o            = rd_q;
  assign stall_cnt_o     = cnt_q;
  assign stall_timeout_o = to_q;

endmodule

// File: tb/tb_id_ex_fwd_pipe.sv
// Directed plus randomized bench for id_ex_fwd_pipe against a behavioural reference model.
module tb_id_ex_fwd_pipe;
  localparam int XL = 32, RA = 5, NF = 3, CW = 10, CNW = 4, MS = 16;

  logic              clk, rst, in_valid, in_ready, flush, out_ready, hazard;
  logic [RA-1:0]     rs1, rs2, rd;
  logic [CW-1:0]     ctrl;
  logic [XL-1:0]     rf1, rf2, imm, pc4;
  logic [NF-1:0]     fvalid, fpend;
  logic [NF*RA-1:0]  frd;
  logic [NF*XL-1:0]  fdata;
  logic [XL-1:0]     fop1, fop2, op1_o, op2_o, imm_o, pc_o;
  logic              out_valid, tmo;
  logic [CW-1:0]     ctrl_o;
  logic [RA-1:0]     rs1_o, rs2_o, rd_o;
  logic [CNW-1:0]    scnt;

  int checks = 0;
  int failures = 0;

  // Reference state of the ID/EX register and counters
  logic          m_valid, m_known, m_to;
  logic [CW-1:0] m_ctrl;
  logic [XL-1:0] m_op1, m_op2, m_imm, m_pc;
  logic [RA-1:0] m_rs1, m_rs2, m_rd;
  int            m_cnt, m_run;

  id_ex_fwd_pipe #(.XLEN(XL), .RA_W(RA), .NUM_FWD(NF), .CTRL_W(CW), .CNT_W(CNW), .MAX_STALL(MS)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .ctrl_i(ctrl), .rf_op1_i(rf1), .rf_op2_i(rf2),
    .imm_i(imm), .pc_plus4_i(pc4), .fwd_valid_i(fvalid), .fwd_pending_i(fpend),
    .fwd_rd_i(frd), .fwd_data_i(fdata), .flush_i(flush), .out_ready_i(out_ready),
    .fwd_op1_o(fop1), .fwd_op2_o(fop2), .hazard_o(hazard), .out_valid_o(out_valid),
    .ctrl_o(ctrl_o), .op1_o(op1_o), .op2_o(op2_o), .imm_o(imm_o), .pc_plus4_o(pc_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .stall_cnt_o(scnt), .stall_timeout_o(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scan sources oldest to youngest so the youngest (lowest index) match overrides the rest.
  function automatic logic [XL-1:0] ref_op(input logic [RA-1:0] rs, input logic [XL-1:0] rf,
                                           output logic pend);
    logic [XL-1:0] r;
    r = rf;
    pend = 1'b0;
    if (rs != 5'd0) begin
      for (int k = NF - 1; k >= 0; k--) begin
        if (fvalid[k] && frd[k*RA +: RA] == rs) begin
          r = fdata[k*XL +: XL];
          pend = fpend[k];
        end
      end
    end
    return r;
  endfunction

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; rst = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; ctrl = 10'd0;
    rf1 = 32'd0; rf2 = 32'd0; imm = 32'd0; pc4 = 32'd0;
    fvalid = 3'd0; fpend = 3'd0; frd = 15'd0; fdata = 96'd0;
  endtask

  task automatic cycle();
    logic p1, p2, hz, le;
    logic [XL-1:0] e1, e2;
    @(negedge clk);
    e1 = ref_op(rs1, rf1, p1);
    e2 = ref_op(rs2, rf2, p2);
    hz = in_valid && (p1 || p2);
    le = out_ready || !m_valid;
    chk("fwd_op1", fop1, e1);
    chk("fwd_op2", fop2, e2);
    chk("hazard", hazard, hz);
    chk("in_ready", in_ready, le && (!hz || flush));
    if (rst) begin
      m_valid = 1'b0; m_ctrl = 10'd0; m_known = 1'b1; m_to = 1'b0;
      m_op1 = 32'd0; m_op2 = 32'd0; m_imm = 32'd0; m_pc = 32'd0;
      m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_cnt = 0; m_run = 0;
    end else begin
      if (hz && !flush) begin
        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        m_run = (m_run < MS) ? m_run + 1 : MS;
        if (m_run >= MS) m_to = 1'b1;
      end else begin
        m_run = 0;
      end
      if (le && !flush && in_valid && !hz) begin
        m_valid = 1'b1; m_ctrl = ctrl; m_known = 1'b1;
        m_op1 = e1; m_op2 = e2; m_imm = imm; m_pc = pc4;
        m_rs1 = rs1; m_rs2 = rs2; m_rd = rd;
      end else if (le) begin
        m_valid = 1'b0; m_ctrl = 10'd0; m_known = 1'b0;
      end else if (flush) begin
        m_valid = 1'b0; m_ctrl = 10'd0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("ctrl", ctrl_o, m_ctrl);
    chk("stall_cnt", scnt, m_cnt);
    chk("timeout", tmo, m_to);
    if (m_known) begin
      chk("op1", op1_o, m_op1);
      chk("op2", op2_o, m_op2);
      chk("imm", imm_o, m_imm);
      chk("pc_plus4", pc_o, m_pc);
      chk("rs1", rs1_o, m_rs1);
      chk("rs2", rs2_o, m_rs2);
      chk("rd", rd_o, m_rd);
    end
  endtask

  initial begin
    int nvalid;
    idle();
    m_valid = 1'b0; m_known = 1'b0; m_to = 1'b0; m_cnt = 0; m_run = 0;
    // Reset with junk on the inputs
    rst = 1'b1; in_valid = 1'b1; ctrl = 10'h3FF; imm = $urandom; rs1 = 5'd3;
    cycle();
    cycle();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_op1", op1_o, 32'd0);
    idle();

    // Youngest of two matching sources wins
    in_valid = 1'b1; rs1 = 5'd5; ctrl = 10'h155; rf1 = 32'hDEAD;
    fvalid = 3'b011; frd = {5'd0, 5'd5, 5'd5}; fdata = {32'd0, 32'hBBBB, 32'hAAAA};
    cycle();
    chk("prio_op1", op1_o, 32'hAAAA);

    // x0 is never forwarded
    idle(); in_valid = 1'b1; rs2 = 5'd0; fvalid = 3'b001; fdata = 96'h1234;
    cycle();
    chk("x0_op2", op2_o, 32'd0);

    // Pending producer stalls for two cycles then forwards
    idle(); in_valid = 1'b1; rs1 = 5'd7; ctrl = 10'h0F0;
    fvalid = 3'b001; fpend = 3'b001; frd = {10'd0, 5'd7}; fdata = 96'h55;
    cycle();
    cycle();
    fpend = 3'b000;
    cycle();
    chk("stall_op1", op1_o, 32'h55);
    chk("stall_cnt2", scnt, 4'd2);

    // Back-pressure holds the register, flush kills it
    idle(); in_valid = 1'b1; out_ready = 1'b0; rf1 = 32'h77; imm = 32'h99;
    cycle();
    chk("hold_op1", op1_o, 32'h55);
    flush = 1'b1;
    cycle();
    chk("flush_valid", out_valid, 1'b0);

    // Eight back-to-back instructions
    idle();
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; imm = 32'd100 + 32'(i); rd = 5'(i + 1); ctrl = 10'(i + 1);
      cycle();
      chk("b2b_imm", imm_o, 32'd100 + 32'(i));
      if (out_valid) nvalid++;
    end
    chk("b2b_count", 32'(nvalid), 32'd8);

    // Long stall: saturation and timeout, then reset mid-stall
    idle(); rst = 1'b1;
    cycle();
    rst = 1'b0; in_valid = 1'b1; rs2 = 5'd9;
    fvalid = 3'b100; fpend = 3'b100; frd = {5'd9, 10'd0};
    for (int i = 1; i <= MS; i++) begin
      cycle();
      if (i == MS - 1) chk("tmo_early", tmo, 1'b0);
    end
    chk("tmo_set", tmo, 1'b1);
    chk("cnt_sat", scnt, 4'd15);
    rst = 1'b1;
    cycle();
    chk("rst_tmo", tmo, 1'b0);
    chk("rst_cnt", scnt, 4'd0);
    chk("rst_imm", imm_o, 32'd0);

    // Randomized traffic with small register space for frequent matches
    idle();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom);
      ctrl = 10'($urandom); rf1 = $urandom; rf2 = $urandom; imm = $urandom; pc4 = $urandom;
      fvalid = 3'($urandom);
      fpend = 3'(($urandom_range(0, 3) == 0) ? $urandom : 0);
      for (int k = 0; k < NF; k++) begin
        frd[k*RA +: RA] = 5'($urandom_range(0, 3));
        fdata[k*XL +: XL] = $urandom;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
